// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad row scanner with column debounce
module keypad_scan #(
  parameter int ROW_DWELL    = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = (ROW_DWELL > 2) ? $clog2(ROW_DWELL) : 2;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROW_DWELL - 1);
  localparam logic [7:0]    DEB_LAST   = 8'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_s;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row_n;
  logic [TW-1:0] r_row_timer;
  logic [1:0]    r_cap_col;
  logic [7:0]    r_deb_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  logic [1:0]    w_next_row;
  logic [3:0]    w_next_row_n;
  logic [1:0]    w_low_col;
  logic          w_col_bit;
  logic [7:0]    w_deb_inc;

  assign keypad_row = r_row_n;
  assign key_code   = r_key_code;
  assign key_valid  = r_key_valid;
  assign key_held   = r_key_held;

  assign w_next_row   = r_row_idx + 2'd1;
  assign w_next_row_n = ~(4'b0001 << w_next_row);
  assign w_col_bit    = r_col_s[r_cap_col];
  assign w_deb_inc    = (r_deb_cnt == 8'hFF) ? r_deb_cnt : r_deb_cnt + 8'd1;

  // Lowest-indexed low column wins when several are pressed on one row
  always_comb begin
    w_low_col = 2'd0;
    if (!r_col_s[0])      w_low_col = 2'd0;
    else if (!r_col_s[1]) w_low_col = 2'd1;
    else if (!r_col_s[2]) w_low_col = 2'd2;
    else if (!r_col_s[3]) w_low_col = 2'd3;
  end

  // Two-flop synchronizer for the asynchronous column sense lines (idle high)
  always_ff @(posedge clk_div) begin
    if (reset) begin
      r_col_meta <= 4'hF;
      r_col_s    <= 4'hF;
    end else begin
      r_col_meta <= keypad_col;
      r_col_s    <= r_col_meta;
    end
  end

  // Scan / debounce / hold state machine with registered outputs
  always_ff @(posedge clk_div) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_row_n     <= 4'b1110;
      r_row_timer <= '0;
      r_cap_col   <= 2'd0;
      r_deb_cnt   <= 8'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_row_timer == TIMER_LAST) begin
            if (r_col_s == 4'b1111) begin
              r_row_idx   <= w_next_row;
              r_row_n     <= w_next_row_n;
              r_row_timer <= '0;
            end else begin
              r_cap_col <= w_low_col;
              r_deb_cnt <= 8'd0;
              r_state   <= ST_DEBOUNCE;
            end
          end else begin
            r_row_timer <= r_row_timer + TW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (w_col_bit) begin
            // Bounce before the count completed: give up and move on
            r_row_idx   <= w_next_row;
            r_row_n     <= w_next_row_n;
            r_row_timer <= '0;
            r_deb_cnt   <= 8'd0;
            r_state     <= ST_SCAN;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_key_code  <= {r_row_idx, r_cap_col};
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_deb_cnt   <= 8'd0;
            r_state     <= ST_HOLD;
          end else begin
            r_deb_cnt <= w_deb_inc;
          end
        end
        ST_HOLD: begin
          if (!w_col_bit) begin
            r_deb_cnt <= 8'd0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_key_held  <= 1'b0;
            r_deb_cnt   <= 8'd0;
            r_row_idx   <= w_next_row;
            r_row_n     <= w_next_row_n;
            r_row_timer <= '0;
            r_state     <= ST_SCAN;
          end else begin
            r_deb_cnt <= w_deb_inc;
          end
        end
        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed scoreboard bench for keypad_scan
module tb_keypad_scan;

  logic        clk_div;
  logic        reset;
  logic [3:0]  keypad_col;
  logic [3:0]  keypad_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  int          sb[$];
  int          n_checks;
  int          n_errors;
  int          pulses;
  int          base;
  logic [3:0]  exp_row;

  keypad_scan #(.ROW_DWELL(4), .DEBOUNCE_CYC(16)) dut (
    .clk_div    (clk_div),
    .reset      (reset),
    .keypad_col (keypad_col),
    .keypad_row (keypad_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  // Passive key matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    keypad_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!keypad_row[r] && pressed[r*4+c]) keypad_col[c] = 1'b0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_div);
    #1;
  endtask

  task automatic wait_pulse(input int b, input string tag);
    for (int i = 0; i < 400 && pulses == b; i++) step();
    chk(tag, pulses - b, 1);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 400 && key_held; i++) step();
    chk(tag, int'(key_held), 0);
  endtask

  // Monitor: row one-hot invariant and scoreboard pop on every accepted key
  always @(negedge clk_div) begin
    if (!reset) chk("row_onehot", $countones(~keypad_row), 1);
    if (key_valid) begin
      pulses++;
      chk("pulse_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        chk("key_code", int'(key_code), sb.pop_front());
        chk("held_at_pulse", int'(key_held), 1);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    pulses   = 0;
    pressed  = 16'h0000;
    reset    = 1'b1;
    repeat (3) @(posedge clk_div);
    step();
    chk("rst_row", int'(keypad_row), 4'b1110);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);

    // Idle scan: each row held low for 4 cycles in order 0,1,2,3
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_row = 4'b1111;
      exp_row[(k/4)%4] = 1'b0;
      chk("idle_row", int'(keypad_row), int'(exp_row));
      step();
    end
    chk("idle_no_pulse", pulses, 0);

    // Solid press of (2,1)
    base = pulses;
    sb.push_back(9);
    pressed[9] = 1'b1;
    wait_pulse(base, "k9_pulse");
    repeat (50) step();
    chk("k9_single", pulses - base, 1);
    chk("k9_held", int'(key_held), 1);
    pressed[9] = 1'b0;
    wait_release("k9_release");
    chk("k9_resume_row3", int'(keypad_row), 4'b0111);
    chk("k9_sb_empty", sb.size(), 0);

    // Bouncing (0,3) then solid
    base = pulses;
    sb.push_back(3);
    for (int i = 0; i < 10; i++) begin
      pressed[3] = ~pressed[3];
      repeat (3) step();
    end
    chk("k3_no_pulse_bounce", pulses - base, 0);
    pressed[3] = 1'b1;
    wait_pulse(base, "k3_pulse");
    pressed[3] = 1'b0;
    wait_release("k3_release");

    // Two keys on row 1: lowest column wins
    base = pulses;
    sb.push_back(4);
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    wait_pulse(base, "k4_pulse");
    repeat (40) step();
    chk("k4_single", pulses - base, 1);
    pressed[4] = 1'b0;
    pressed[6] = 1'b0;
    wait_release("k4_release");

    // Hold (3,3), press (0,0) during hold, then release (3,3)
    base = pulses;
    sb.push_back(15);
    pressed[15] = 1'b1;
    wait_pulse(base, "k15_pulse");
    pressed[0] = 1'b1;
    repeat (60) step();
    chk("k15_no_second", pulses - base, 1);
    base = pulses;
    sb.push_back(0);
    pressed[15] = 1'b0;
    wait_pulse(base, "k0_pulse");
    repeat (30) step();
    chk("k0_single", pulses - base, 1);
    pressed[0] = 1'b0;
    wait_release("k0_release");

    // Reset 5 cycles into debounce of (1,1)
    base = pulses;
    for (int i = 0; i < 40 && keypad_row != 4'b1110; i++) step();
    pressed[5] = 1'b1;
    for (int i = 0; i < 40 && keypad_row != 4'b1101; i++) step();
    chk("k5_row1_reached", int'(keypad_row), 4'b1101);
    repeat (4) step();
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("mid_rst_row", int'(keypad_row), 4'b1110);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_held", int'(key_held), 0);
    step();
    pressed[5] = 1'b0;
    reset = 1'b0;
    repeat (40) step();
    chk("mid_rst_no_pulse", pulses - base, 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter ROW_DWELL, default 4, sets the clk_div cycles each row is driven before its columns are evaluated; legal minimum is 3.
REQ-002 Parameter DEBOUNCE_CYC, default 16, sets the consecutive stable samples needed to accept a press or a release; legal range is 1..255.
REQ-003 clk_div  input  1  sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 keypad_col  input  4  column sense lines, active-low, pulled up externally, asynchronous to clk_div.
REQ-006 keypad_row  output  4  row drive lines, active-low one-hot; row n is low when bit n = 0.
REQ-007 key_code  output  4  code of the last accepted key, equal to row*4 + col.
REQ-007a key_code is registered and holds its value until the next accepted press.
REQ-008 key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 key_held  output  1  high from acceptance of a press until its debounced release.

Function
REQ-010 keypad_col shall pass through a 2-flop synchronizer; the second-stage output is col_s, and all decisions use only col_s.
REQ-011 The FSM shall have exactly three states: SCAN, DEBOUNCE and HOLD.
REQ-012 In SCAN, row_idx (0..3) shall select the driven row, and row_timer shall count 0..ROW_DWELL-1.
REQ-013 In SCAN, when row_timer = ROW_DWELL-1 and col_s = 4'b1111, the block shall advance row_idx (3 wraps to 0) and clear row_timer.
REQ-014 In SCAN, when row_timer = ROW_DWELL-1 and col_s != 4'b1111, the block shall capture row_idx and the lowest-indexed low bit of col_s as cap_col, clear deb_cnt and enter DEBOUNCE.
REQ-015 If several columns are low at that point, the lowest index wins and the other columns are ignored.
REQ-016 In DEBOUNCE, the row shall stay driven.
REQ-016a In DEBOUNCE, each cycle with col_s[cap_col] = 0 shall increment deb_cnt.
REQ-017 In DEBOUNCE, when deb_cnt reaches DEBOUNCE_CYC, the block shall update key_code, pulse key_valid for one cycle, set key_held, clear deb_cnt and enter HOLD.
REQ-017a key_valid shall coincide with the cycle in which key_code first shows the new value.
REQ-018 In DEBOUNCE, col_s[cap_col] = 1 before the count completes shall abort to SCAN with the next row_idx and row_timer = 0, and shall not pulse key_valid.
REQ-019 In HOLD, the row shall stay driven.
REQ-019a In HOLD, each cycle with col_s[cap_col] = 1 shall increment deb_cnt, and any cycle with col_s[cap_col] = 0 shall clear it.
REQ-020 In HOLD, when deb_cnt reaches DEBOUNCE_CYC, the block shall clear key_held and return to SCAN with the next row_idx.
REQ-020a In HOLD, presses on other keys shall be ignored, so a key produces no repeat pulses and no second key is accepted.
REQ-021 keypad_row shall always be exactly one-hot low (never 4'b1111 or multi-low) outside reset.
REQ-022 deb_cnt shall be 8 bits wide and shall saturate rather than wrap.

Reset
REQ-023 While reset = 1 at a clock edge:
- keypad_row = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0;
- state = SCAN, row_idx = 0, row_timer = 0, deb_cnt = 0;
- synchronizer flops set to 4'b1111.
REQ-024 Reset asserted mid-DEBOUNCE or mid-HOLD shall abandon the operation with no key_valid pulse; after release, scanning restarts from row 0.

Verification
REQ-025 Hold key (row 2, col 1) pressed solidly, with defaults -> exactly one key_valid pulse with key_code = 9, key_held = 1 until release.
REQ-025a The same press -> after release is stable for 16 cycles, key_held = 0 and scanning resumes at row 3.
REQ-026 Press (0,3) bouncing low/high every 3 cycles for 30 cycles, then solid -> no pulse during the bounce; one pulse with key_code = 3 once stable for 16 samples.
REQ-027 Press (1,0) and (1,2) simultaneously -> key_code = 4 only; one key_valid pulse.
REQ-028 Hold (3,3), then during HOLD also press (0,0) -> no second pulse.
REQ-028a The same sequence: after (3,3) is released and (0,0) remains pressed, exactly one pulse with key_code = 0 on the subsequent scan.
REQ-029 Assert reset 5 cycles into DEBOUNCE -> key_valid stays 0 and keypad_row = 4'b1110 on the next cycle.
REQ-029a With no key pressed for 64 cycles -> keypad_row cycles 1110, 1101, 1011, 0111, each held for 4 cycles, and key_valid stays 0.
